mult16_seq: RTL and testbench
=============================

Name: mult16_seq

Overview:
- Iterative shift-and-add multiplier that sits directly upstream of the existing 16-bit ripple adder (Add16) and drives its a/b operands every cycle.
- Computes a*b modulo 2^16, matching Hack 16-bit wrap semantics.
- Serves as the hardware replacement for the software multiply routine.
- Exposes a start/busy/done handshake to the CPU-side controller.

Parameters:
- EARLY_EXIT, 1, 1 = finish as soon as the remaining multiplier bits are all zero; 0 = always run exactly 16 iterations.

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled on the rising edge of clk
- a  input  16  multiplicand; captured only on an accepted start
- b  input  16  multiplier; captured only on an accepted start
- busy  output  1  high while state = RUN
- done  output  1  one-cycle pulse when product is final
- product  output  16  accumulator register; low 16 bits of a*b

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All state changes on the rising edge of clk only.
- Reset: state=IDLE, acc=0, mcand=0, mplier=0, count=0. Outputs: busy=0, done=0, product=0.
- Reset has priority over everything, including mid-RUN: the operation is abandoned, no done pulse is produced, and product=0.
- States:
  - IDLE: waiting for start.
  - RUN: one iteration per cycle.
  - DONE: done=1 for exactly one cycle.
- Start acceptance: start is accepted in IDLE or DONE.
  - On acceptance: acc<=0, mcand<=a, mplier<=b, count<=0, state<=RUN.
  - start while in RUN is ignored. Operands are not re-captured and no queueing occurs.
- RUN iteration (each edge):
  - If mplier[0]=1, acc<=Add16(acc, mcand).sum. Otherwise acc holds.
  - mcand<=mcand<<1, zero fill; bits shifted out of bit 15 are discarded.
  - mplier<=mplier>>1, zero fill.
  - count<=count+1.
- RUN exit to DONE:
  - Exit when count==15 (after 16 iterations).
  - Or, if EARLY_EXIT=1, exit when the shifted mplier (mplier>>1) == 0.
  - Otherwise remain in RUN.
- DONE: done=1 and busy=0 for one cycle, then IDLE unless start is accepted in that same cycle.
- Latency: start accepted at edge k gives done high during the cycle after edge k+N.
  - N = 16 when EARLY_EXIT=0.
  - N = max(1, index of the highest set bit of b, plus 1) when EARLY_EXIT=1.
  - b=0 therefore gives N=1.
- product: always equals acc. It updates during RUN and holds its final value from DONE until the next accepted start, which clears it to 0.
- Adder usage: Add16 is the only arithmetic element. Its carry-out does not exist, so overflow is silently discarded, consistent with Hack 16-bit wrap.
- The a and b inputs may change freely after acceptance without affecting the result.

Decomposition:
- Shared include file mult16_defs.vh holds:
  - state localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - ITER_MAX=4'd15.
- Sub-module: reuse the existing Add16 unchanged, instantiated once with a=acc, b=mcand.
- No other sub-modules. The FSM and shift registers live in mult16_seq.

Test Plan:
- Reset, then start with a=3, b=5, EARLY_EXIT=1 -> busy for 3 cycles, one done pulse, product=15 (0x000F) held until the next start.
- a=0x1234, b=0 -> busy for 1 cycle, done pulse, product=0x0000. Repeat with EARLY_EXIT=0 -> busy for exactly 16 cycles, product=0x0000.
- a=0xFFFF, b=0xFFFF -> product=0x0001 after 16 RUN cycles. a=0x0100, b=0x0100 -> product=0x0000 (wrap).
- Start a=7, b=6. In the 2nd RUN cycle assert start with a=100, b=100 -> ignored, product=42. Then assert start in the done cycle with a=2, b=9 -> accepted back-to-back, product=18.
- Start a=0x00FF, b=0x00FF, assert reset in the 4th RUN cycle -> next cycle state=IDLE, busy=0, product=0, no done pulse. A following start with a=4, b=4 gives product=16.
- Random a/b regression, both EARLY_EXIT settings -> product == (a*b) & 0xFFFF, exactly one done pulse per accepted start, latency matching the formula.

Source files
------------

// File: rtl/mult16_seq_pkg.sv
// Shared FSM encoding and iteration limit for the sequential 16x16 multiplier.
package mult16_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ITER_MAX = 4'd15;

endpackage

// File: rtl/mult16_seq_add16.sv
// 16-bit ripple-carry adder; the carry out of bit 15 is dropped (16-bit wrap).
module mult16_seq_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  always_comb begin
    logic carry;
    carry = 1'b0;
    sum   = 16'd0;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/mult16_seq.sv
// Iterative shift-and-add multiplier producing the low 16 bits of a*b with a
// start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift-and-add iteration per cycle
// DONE  | product final, done pulses for one cycle
module mult16_seq
  import mult16_seq_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  state_t      state, state_nx;
  logic [15:0] acc, mcand, mplier, sum;
  logic [3:0]  count;
  logic        accept;

  mult16_seq_add16 u_add16 (
    .a   (acc),
    .b   (mcand),
    .sum (sum)
  );

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // mplier[15:1] is the multiplier as it will look after this shift
        if (count == ITER_MAX || (EARLY_EXIT && mplier[15:1] == 15'd0)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= 16'd0;
      mcand  <= 16'd0;
      mplier <= 16'd0;
      count  <= 4'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        acc    <= 16'd0;
        mcand  <= a;
        mplier <= b;
        count  <= 4'd0;
      end else if (state == RUN) begin
        if (mplier[0]) begin
          acc <= sum;
        end
        mcand  <= {mcand[14:0], 1'b0};
        mplier <= {1'b0, mplier[15:1]};
        count  <= count + 4'd1;
      end
    end
  end

  assign product = acc;

endmodule

// File: tb/tb_mult16_seq.sv
// Scoreboard bench for mult16_seq: instance 0 uses early exit, instance 1
// always runs 16 iterations.
module tb_mult16_seq;

  logic        clk = 1'b0;
  logic        rst_s   [2];
  logic        start_s [2];
  logic [15:0] a_s     [2];
  logic [15:0] b_s     [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [15:0] prod_s  [2];

  int tests = 0;
  int fails = 0;
  int done_cnt [2];

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mult16_seq #(.EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .product(prod_s[0])
  );

  mult16_seq #(.EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .product(prod_s[1])
  );

  initial begin
    done_cnt[0] = 0;
    done_cnt[1] = 0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_s[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  function automatic int lat_model(input int d, input logic [15:0] y);
    int n;
    if (d == 1) return 16;
    n = 1;
    for (int i = 0; i < 16; i++) begin
      if (y[i]) n = i + 1;
    end
    return n;
  endfunction

  // Counts busy cycles at each negedge until done is seen (bounded).
  task automatic wait_done(input int d, input string nm, output int n);
    int guard;
    n = 0;
    guard = 0;
    while (done_s[d] !== 1'b1 && guard < 40) begin
      if (busy_s[d] === 1'b1) n++;
      @(negedge clk);
      guard++;
    end
    tests++;
    if (done_s[d] !== 1'b1) begin
      fails++;
      $display("FAIL %s timeout: done=%b after %0d cycles, want done=1", nm, done_s[d], guard);
    end
  endtask

  task automatic check_done(input int d, input string nm, input int n);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard: queue empty at done, want one entry", nm);
      return;
    end
    e = sb.pop_front();
    if (prod_s[d] !== e.prod) begin
      fails++;
      $display("FAIL %s product: got %h want %h", nm, prod_s[d], e.prod);
    end
    tests++;
    if (n !== e.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d busy cycles want %0d", nm, n, e.lat);
    end
    tests++;
    if (busy_s[d] !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_in_done: got %b want 0", nm, busy_s[d]);
    end
  endtask

  task automatic check_hold(input int d, input string nm, input logic [15:0] want,
                            input int dc0, input int pulses);
    repeat (2) @(negedge clk);
    tests++;
    if (prod_s[d] !== want || done_s[d] !== 1'b0 || busy_s[d] !== 1'b0) begin
      fails++;
      $display("FAIL %s hold: got product=%h done=%b busy=%b want %h/0/0",
               nm, prod_s[d], done_s[d], busy_s[d], want);
    end
    tests++;
    if (done_cnt[d] - dc0 !== pulses) begin
      fails++;
      $display("FAIL %s done_pulses: got %0d want %0d", nm, done_cnt[d] - dc0, pulses);
    end
  endtask

  task automatic run_op(input int d, input logic [15:0] x, input logic [15:0] y,
                        input string nm);
    exp_t e;
    int   n, dc0;
    logic [15:0] p;
    p = x * y;
    e.prod = p;
    e.lat  = lat_model(d, y);
    @(negedge clk);
    dc0 = done_cnt[d];
    start_s[d] = 1'b1;
    a_s[d] = x;
    b_s[d] = y;
    sb.push_back(e);
    @(negedge clk);
    start_s[d] = 1'b0;
    a_s[d] = 16'($urandom);
    b_s[d] = 16'($urandom);
    wait_done(d, nm, n);
    check_done(d, nm, n);
    check_hold(d, nm, p, dc0, 1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1;
      start_s[i] = 1'b0;
      a_s[i] = 16'hAAAA;
      b_s[i] = 16'h5555;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (busy_s[i] !== 1'b0 || done_s[i] !== 1'b0 || prod_s[i] !== 16'h0000) begin
        fails++;
        $display("FAIL reset[%0d]: got busy=%b done=%b product=%h want 0/0/0000",
                 i, busy_s[i], done_s[i], prod_s[i]);
      end
      rst_s[i] = 1'b0;
    end
  endtask

  task automatic test_basic();
    run_op(0, 16'd3, 16'd5, "3x5_ee");
    run_op(0, 16'h1234, 16'h0000, "b0_ee");
    run_op(1, 16'h1234, 16'h0000, "b0_full");
    run_op(1, 16'd3, 16'd5, "3x5_full");
  endtask

  task automatic test_wrap();
    run_op(1, 16'hFFFF, 16'hFFFF, "ffff_full");
    run_op(0, 16'hFFFF, 16'hFFFF, "ffff_ee");
    run_op(0, 16'h0100, 16'h0100, "wrap_ee");
    run_op(1, 16'h0100, 16'h0100, "wrap_full");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n, n2, dc0;
    @(negedge clk);
    dc0 = done_cnt[0];
    start_s[0] = 1'b1; a_s[0] = 16'd7; b_s[0] = 16'd6;
    e.prod = 16'd42; e.lat = 3;
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    start_s[0] = 1'b0;
    if (busy_s[0] === 1'b1) n++;
    @(negedge clk);
    if (busy_s[0] === 1'b1) n++;
    start_s[0] = 1'b1; a_s[0] = 16'd100; b_s[0] = 16'd100;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_done(0, "b2b_first", n2);
    check_done(0, "b2b_first", n + n2);
    start_s[0] = 1'b1; a_s[0] = 16'd2; b_s[0] = 16'd9;
    e.prod = 16'd18; e.lat = 4;
    sb.push_back(e);
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_done(0, "b2b_second", n);
    check_done(0, "b2b_second", n);
    check_hold(0, "b2b", 16'd18, dc0, 2);
  endtask

  task automatic test_reset_midrun();
    int dc0;
    @(negedge clk);
    dc0 = done_cnt[0];
    start_s[0] = 1'b1; a_s[0] = 16'h00FF; b_s[0] = 16'h00FF;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_s[0] = 1'b1;
    @(negedge clk);
    tests++;
    if (busy_s[0] !== 1'b0 || done_s[0] !== 1'b0 || prod_s[0] !== 16'h0000) begin
      fails++;
      $display("FAIL midrun_reset: got busy=%b done=%b product=%h want 0/0/0000",
               busy_s[0], done_s[0], prod_s[0]);
    end
    rst_s[0] = 1'b0;
    repeat (12) @(negedge clk);
    tests++;
    if (done_cnt[0] !== dc0 || prod_s[0] !== 16'h0000) begin
      fails++;
      $display("FAIL midrun_abandon: got pulses=%0d product=%h want 0/0000",
               done_cnt[0] - dc0, prod_s[0]);
    end
    run_op(0, 16'd4, 16'd4, "after_reset");
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    logic [31:0] m;
    int          sh;
    for (int i = 0; i < 24; i++) begin
      x  = 16'($urandom);
      y  = 16'($urandom);
      sh = $urandom_range(0, 16);
      m  = (32'd1 << sh) - 32'd1;
      y  = y & m[15:0];
      run_op(i % 2, x, y, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
